adjlist_sched: RTL and testbench
================================

Name: adjlist_sched

Overview:
- Controller between the hashed-node stream and the shared edge RAM.
- Consumes per-line node numbers: the first node of a line is the source and each later node is a destination.
- Schedules one reverse-edge write per destination into the bank selected by the destination's top bits, and drives per-bank backpressure to the node stream.
- Records the start ("you") and end ("out") node numbers and signals graph-load completion for the path-count engine.

Parameters:
NODE_W, 12, node number width
BANK_BITS, 6, bank index width (bank = node[NODE_W-1 -: BANK_BITS]); 2**BANK_BITS banks
SLOT_W, 6, per-bank edge slot index width (2**SLOT_W edges per bank)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_node_num  in  NODE_W  hashed node number
i_node_vld  in  1  node valid; accepted when i_node_vld & ~o_stall[bank(i_node_num)]
i_startnode  in  1  qualifies i_node_num as "you"; aligned with i_node_vld
i_endnode  in  1  qualifies i_node_num as "out"; aligned with i_node_vld
i_line_end  in  1  end-of-line marker token, never stalled; never concurrent with i_node_vld
o_stall  out  2**BANK_BITS  per-bank stall to node stream
o_wr_vld  out  1  edge write request
o_wr_addr  out  BANK_BITS+SLOT_W  {bank(dst), slot}
o_wr_src  out  NODE_W  predecessor (line source)
o_wr_dst  out  NODE_W  destination node
i_wr_rdy  in  1  edge RAM accepts write
o_start_num  out  NODE_W  captured "you" number
o_end_num  out  NODE_W  captured "out" number
o_graph_done  out  1  sticky; load complete
o_error  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0, state SRC, all slot counters 0, pending write dropped, start/end-seen flags cleared. Reset mid-operation discards everything.
- States: SRC, DST, DONE.
- SRC:
  - Accepted node -> latch as src_q, go to DST; no write issued.
  - i_line_end -> empty line, go to DONE.
- DST:
  - Accepted node -> load the output register with {addr = {bank(node), cnt[bank]}, src_q, node}; cnt[bank]++.
  - i_line_end -> SRC.
- DONE:
  - o_graph_done = 1 once the output register is empty.
  - Any i_node_vld -> o_error.
- Latency: a destination accepted in cycle t appears on o_wr_vld in t+1.
- Output register: single entry. It loads when empty, or when i_wr_rdy is high in the same cycle (back-to-back writes at 1/cycle). o_wr_* hold stable while o_wr_vld & ~i_wr_rdy.
- o_stall[b] = (o_wr_vld & ~i_wr_rdy) | (state==DST & cnt[b]==2**SLOT_W-1 full-marker). Counters saturate; the last slot is reserved, so usable capacity is 2**SLOT_W-1 edges per bank. Stall is combinational from registered state only.
- Start/end capture: an accepted node with i_startnode loads o_start_num and sets start_seen; likewise for i_endnode/o_end_num. A repeat flag with a different number -> o_error, value kept.
- Entering DONE with start_seen==0 or end_seen==0 -> o_error.
- Simultaneous i_node_vld and i_line_end -> o_error; the line_end is honoured and the node is dropped.
- Stall never blocks i_line_end. A state change to SRC while a write is pending is legal, because the pending entry holds its own src copy.

Optional Feature:
- Macro ADJLIST_SELF_LOOP_FILTER_EN.
- Defined: an accepted destination equal to src_q is consumed without a write and without a counter increment.
- Undefined: self-loops are written like any other edge.

Decomposition:
- adjlist_pkg holds:
  - NODE_W, BANK_BITS, SLOT_W defaults
  - state enum {SRC, DST, DONE}
  - edge_t struct {addr, src, dst}
  - bank() helper function
- One sub-module, adjlist_slot_ctr: the bank of 2**BANK_BITS saturating SLOT_W counters with increment index and a full-vector output.

Test Plan:
- Line "you a b", then line_end, then empty line (you=0x2A1, a=0x040, b=0x081), i_wr_rdy=1 -> two writes:
  - addr {1,0} src 0x2A1 dst 0x040
  - addr {2,0} src 0x2A1 dst 0x081
  - o_graph_done=1; o_error=1 (end never seen).
- Full graph with "out"=0x3C5 as a destination, i_wr_rdy held low 5 cycles -> o_stall all ones from t+1 and o_wr_* stable. On release, the write completes and the next dst is accepted the same cycle.
- 63 destinations into bank 5 -> cnt[5] full, o_stall[5]=1 and other bits 0. A dst in bank 6 is still accepted and written at slot 0.
- Node with i_startnode=1 num 0x010, later i_startnode=1 num 0x011 -> o_error=1, o_start_num stays 0x010.
- Line "0x123 0x123 0x200" -> with macro: one write (dst 0x200); without macro: two writes, cnt[4] becomes 1.
- Reset asserted while o_wr_vld=1 and i_wr_rdy=0 -> next cycle o_wr_vld=0, all counters 0, state SRC, o_error/o_graph_done=0.

Source files
------------

// File: rtl/adjlist_pkg.sv
// Shared types and helpers for the adjacency-list edge scheduler.
// Widths here are the build defaults for the whole slice.
package adjlist_pkg;

    localparam int NODE_W    = 12;
    localparam int BANK_BITS = 6;
    localparam int SLOT_W    = 6;
    localparam int NBANK     = 1 << BANK_BITS;
    localparam int ADDR_W    = BANK_BITS + SLOT_W;

    typedef enum logic [1:0] {
        SRC  = 2'd0,
        DST  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [NODE_W-1:0] src;
        logic [NODE_W-1:0] dst;
    } edge_t;

    function automatic logic [BANK_BITS-1:0] bank(input logic [NODE_W-1:0] node);
        return node[NODE_W-1 -: BANK_BITS];
    endfunction

endpackage

// File: rtl/adjlist_slot_ctr.sv
// Per-bank saturating edge-slot counters; the all-ones value marks a full bank.
module adjlist_slot_ctr
    import adjlist_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_en,
    input  logic [BANK_BITS-1:0] inc_idx,
    output logic [SLOT_W-1:0]    cnt,
    output logic [NBANK-1:0]     full
);

    localparam logic [SLOT_W-1:0] SLOT_MAX = '1;

    logic [SLOT_W-1:0] cnt_q [NBANK];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) cnt_q[b] <= '0;
        end else if (inc_en && cnt_q[inc_idx] != SLOT_MAX) begin
            cnt_q[inc_idx] <= cnt_q[inc_idx] + 1'b1;
        end
    end

    always_comb begin
        full = '0;
        for (int b = 0; b < NBANK; b++) full[b] = (cnt_q[b] == SLOT_MAX);
    end

    assign cnt = cnt_q[inc_idx];

endmodule

// File: rtl/adjlist_sched.sv
// Node-stream to edge-RAM scheduler: one reverse-edge write per destination.
// Optional build macro ADJLIST_SELF_LOOP_FILTER_EN drops self-loop edges.
module adjlist_sched
    import adjlist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NODE_W-1:0] i_node_num,
    input  logic              i_node_vld,
    input  logic              i_startnode,
    input  logic              i_endnode,
    input  logic              i_line_end,
    output logic [NBANK-1:0]  o_stall,
    output logic              o_wr_vld,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [NODE_W-1:0] o_wr_src,
    output logic [NODE_W-1:0] o_wr_dst,
    input  logic              i_wr_rdy,
    output logic [NODE_W-1:0] o_start_num,
    output logic [NODE_W-1:0] o_end_num,
    output logic              o_graph_done,
    output logic              o_error,
    output logic [1:0]        o_dbg_state
);

    localparam logic [1:0] S_SRC  = SRC;
    localparam logic [1:0] S_DST  = DST;
    localparam logic [1:0] S_DONE = DONE;

    // Handshake: a write moves when o_wr_vld & i_wr_rdy; o_wr_* hold while
    // o_wr_vld & ~i_wr_rdy. A node moves when i_node_vld & ~o_stall[bank].
    logic [1:0]           state_q;
    logic [NODE_W-1:0]    src_q;
    edge_t                wr_q;
    logic                 wr_vld_q;
    logic                 start_seen_q, end_seen_q;
    logic [NODE_W-1:0]    start_q, end_q;
    logic                 done_q, err_q;

    logic [BANK_BITS-1:0] bank_in;
    logic [SLOT_W-1:0]    slot;
    logic [NBANK-1:0]     full;
    logic                 pending, node_acc, self_loop, dst_wr;
    logic                 start_bad, end_bad, done_bad, err_set;

    assign bank_in = bank(i_node_num);
    assign pending = wr_vld_q & ~i_wr_rdy;
    assign o_stall = {NBANK{pending}} | ({NBANK{state_q == S_DST}} & full);

    assign node_acc = i_node_vld & ~i_line_end & ~o_stall[bank_in] & (state_q != S_DONE);

`ifdef ADJLIST_SELF_LOOP_FILTER_EN
    assign self_loop = (i_node_num == src_q);
`else
    assign self_loop = 1'b0;
`endif

    assign dst_wr = node_acc & (state_q == S_DST) & ~self_loop;

    adjlist_slot_ctr u_slot_ctr (
        .clk     (clk),
        .rst     (rst),
        .inc_en  (dst_wr),
        .inc_idx (bank_in),
        .cnt     (slot),
        .full    (full)
    );

    assign start_bad = node_acc & i_startnode & start_seen_q & (i_node_num != start_q);
    assign end_bad   = node_acc & i_endnode & end_seen_q & (i_node_num != end_q);
    assign done_bad  = (state_q == S_SRC) & i_line_end & ~(start_seen_q & end_seen_q);
    assign err_set   = (i_node_vld & i_line_end) | ((state_q == S_DONE) & i_node_vld)
                     | start_bad | end_bad | done_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_SRC;
            src_q        <= '0;
            wr_q         <= '0;
            wr_vld_q     <= 1'b0;
            start_seen_q <= 1'b0;
            end_seen_q   <= 1'b0;
            start_q      <= '0;
            end_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_SRC: begin
                    if (i_line_end) begin
                        state_q <= S_DONE;
                    end else if (node_acc) begin
                        src_q   <= i_node_num;
                        state_q <= S_DST;
                    end
                end
                S_DST:   if (i_line_end) state_q <= S_SRC;
                default: state_q <= S_DONE;
            endcase

            // The entry carries its own src copy, so leaving DST never corrupts it.
            if (dst_wr) begin
                wr_q.addr <= {bank_in, slot};
                wr_q.src  <= src_q;
                wr_q.dst  <= i_node_num;
                wr_vld_q  <= 1'b1;
            end else if (i_wr_rdy) begin
                wr_vld_q  <= 1'b0;
            end

            if (node_acc && i_startnode && !start_seen_q) begin
                start_q      <= i_node_num;
                start_seen_q <= 1'b1;
            end
            if (node_acc && i_endnode && !end_seen_q) begin
                end_q      <= i_node_num;
                end_seen_q <= 1'b1;
            end

            if (state_q == S_DONE && !wr_vld_q) done_q <= 1'b1;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign o_wr_vld     = wr_vld_q;
    assign o_wr_addr    = wr_q.addr;
    assign o_wr_src     = wr_q.src;
    assign o_wr_dst     = wr_q.dst;
    assign o_start_num  = start_q;
    assign o_end_num    = end_q;
    assign o_graph_done = done_q;
    assign o_error      = err_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_adjlist_sched.sv
// Directed bench for adjlist_sched with hand-computed expectations.
// Self-loop expectations follow ADJLIST_SELF_LOOP_FILTER_EN.
module tb_adjlist_sched;

`ifdef ADJLIST_SELF_LOOP_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] i_node_num = '0;
    logic        i_node_vld = 1'b0;
    logic        i_startnode = 1'b0;
    logic        i_endnode = 1'b0;
    logic        i_line_end = 1'b0;
    logic [63:0] o_stall;
    logic        o_wr_vld;
    logic [11:0] o_wr_addr;
    logic [11:0] o_wr_src;
    logic [11:0] o_wr_dst;
    logic        i_wr_rdy = 1'b0;
    logic [11:0] o_start_num;
    logic [11:0] o_end_num;
    logic        o_graph_done;
    logic        o_error;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adjlist_sched dut (
        .clk          (clk),
        .rst          (rst),
        .i_node_num   (i_node_num),
        .i_node_vld   (i_node_vld),
        .i_startnode  (i_startnode),
        .i_endnode    (i_endnode),
        .i_line_end   (i_line_end),
        .o_stall      (o_stall),
        .o_wr_vld     (o_wr_vld),
        .o_wr_addr    (o_wr_addr),
        .o_wr_src     (o_wr_src),
        .o_wr_dst     (o_wr_dst),
        .i_wr_rdy     (i_wr_rdy),
        .o_start_num  (o_start_num),
        .o_end_num    (o_end_num),
        .o_graph_done (o_graph_done),
        .o_error      (o_error),
        .o_dbg_state  (o_dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic node(input logic [11:0] num, input logic s, input logic e);
        i_node_num  = num;
        i_node_vld  = 1'b1;
        i_startnode = s;
        i_endnode   = e;
        tick();
        i_node_vld  = 1'b0;
        i_startnode = 1'b0;
        i_endnode   = 1'b0;
    endtask

    task automatic line_end();
        i_line_end = 1'b1;
        tick();
        i_line_end = 1'b0;
    endtask

    initial begin
        // Test 1: "you a b", line_end, empty line
        i_wr_rdy = 1'b1;
        do_reset();
        chk("rst_state", 64'(o_dbg_state), 64'd0);
        chk("rst_vld", 64'(o_wr_vld), 64'd0);
        chk("rst_stall", o_stall, 64'd0);
        chk("rst_err", 64'(o_error), 64'd0);
        chk("rst_done", 64'(o_graph_done), 64'd0);
        node(12'h2A1, 1'b1, 1'b0);
        chk("t1_state_dst", 64'(o_dbg_state), 64'd1);
        chk("t1_src_nowrite", 64'(o_wr_vld), 64'd0);
        chk("t1_start", 64'(o_start_num), 64'h2A1);
        node(12'h040, 1'b0, 1'b0);
        chk("t1_w1_vld", 64'(o_wr_vld), 64'd1);
        chk("t1_w1_addr", 64'(o_wr_addr), 64'h040);
        chk("t1_w1_src", 64'(o_wr_src), 64'h2A1);
        chk("t1_w1_dst", 64'(o_wr_dst), 64'h040);
        node(12'h081, 1'b0, 1'b0);
        chk("t1_w2_vld", 64'(o_wr_vld), 64'd1);
        chk("t1_w2_addr", 64'(o_wr_addr), 64'h080);
        chk("t1_w2_src", 64'(o_wr_src), 64'h2A1);
        chk("t1_w2_dst", 64'(o_wr_dst), 64'h081);
        line_end();
        chk("t1_state_src", 64'(o_dbg_state), 64'd0);
        chk("t1_drained", 64'(o_wr_vld), 64'd0);
        chk("t1_err_before", 64'(o_error), 64'd0);
        line_end();
        chk("t1_state_done", 64'(o_dbg_state), 64'd2);
        chk("t1_err_noend", 64'(o_error), 64'd1);
        tick();
        chk("t1_graph_done", 64'(o_graph_done), 64'd1);

        // Test 2: backpressure with "out" as a destination
        do_reset();
        i_wr_rdy = 1'b1;
        node(12'h010, 1'b1, 1'b0);
        i_wr_rdy = 1'b0;
        node(12'h3C5, 1'b0, 1'b1);
        chk("t2_end", 64'(o_end_num), 64'h3C5);
        i_node_num = 12'h0C7;
        i_node_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_all", o_stall, {64{1'b1}});
            chk("t2_hold_vld", 64'(o_wr_vld), 64'd1);
            chk("t2_hold_addr", 64'(o_wr_addr), 64'h3C0);
            chk("t2_hold_dst", 64'(o_wr_dst), 64'h3C5);
            tick();
        end
        i_wr_rdy = 1'b1;
        #1;
        chk("t2_release_stall", o_stall, 64'd0);
        tick();
        i_node_vld = 1'b0;
        chk("t2_next_vld", 64'(o_wr_vld), 64'd1);
        chk("t2_next_addr", 64'(o_wr_addr), 64'h0C0);
        chk("t2_next_dst", 64'(o_wr_dst), 64'h0C7);
        chk("t2_next_src", 64'(o_wr_src), 64'h010);
        line_end();
        line_end();
        chk("t2_state_done", 64'(o_dbg_state), 64'd2);
        chk("t2_err_clean", 64'(o_error), 64'd0);
        chk("t2_done_wait", 64'(o_graph_done), 64'd0);
        tick();
        chk("t2_graph_done", 64'(o_graph_done), 64'd1);
        node(12'h001, 1'b0, 1'b0);
        chk("t2_node_in_done", 64'(o_error), 64'd1);

        // Test 3: fill bank 5, bank 6 still flows
        do_reset();
        node(12'h2A1, 1'b0, 1'b0);
        for (int i = 0; i < 63; i++) node(12'h140 + 12'(i), 1'b0, 1'b0);
        chk("t3_last_addr", 64'(o_wr_addr), 64'h17E);
        chk("t3_stall5", o_stall, 64'h20);
        node(12'h150, 1'b0, 1'b0);
        chk("t3_blocked", 64'(o_wr_vld), 64'd0);
        node(12'h180, 1'b0, 1'b0);
        chk("t3_b6_vld", 64'(o_wr_vld), 64'd1);
        chk("t3_b6_addr", 64'(o_wr_addr), 64'h180);
        chk("t3_b6_dst", 64'(o_wr_dst), 64'h180);

        // Test 4: conflicting start
        do_reset();
        node(12'h010, 1'b1, 1'b0);
        chk("t4_err0", 64'(o_error), 64'd0);
        node(12'h011, 1'b1, 1'b0);
        chk("t4_err1", 64'(o_error), 64'd1);
        chk("t4_start_kept", 64'(o_start_num), 64'h010);

        // Test 5: self-loop line "0x123 0x123 0x200", then probe cnt[4]
        do_reset();
        node(12'h123, 1'b0, 1'b0);
        node(12'h123, 1'b0, 1'b0);
        chk("t5_self_vld", 64'(o_wr_vld), FILT ? 64'd0 : 64'd1);
        chk("t5_self_dst", 64'(o_wr_dst), FILT ? 64'd0 : 64'h123);
        node(12'h200, 1'b0, 1'b0);
        chk("t5_w_addr", 64'(o_wr_addr), 64'h200);
        chk("t5_w_dst", 64'(o_wr_dst), 64'h200);
        node(12'h124, 1'b0, 1'b0);
        chk("t5_cnt4", 64'(o_wr_addr), FILT ? 64'h100 : 64'h101);

        // Test 6: reset while a write is pending
        do_reset();
        node(12'h2A1, 1'b0, 1'b0);
        i_wr_rdy = 1'b0;
        node(12'h0C7, 1'b0, 1'b0);
        chk("t6_pending", 64'(o_wr_vld), 64'd1);
        i_node_num = 12'h0C8;
        i_node_vld = 1'b1;
        i_line_end = 1'b1;
        tick();
        i_node_vld = 1'b0;
        i_line_end = 1'b0;
        chk("t6_vld_le_err", 64'(o_error), 64'd1);
        chk("t6_vld_le_src", 64'(o_dbg_state), 64'd0);
        chk("t6_held_dst", 64'(o_wr_dst), 64'h0C7);
        do_reset();
        chk("t6_rst_vld", 64'(o_wr_vld), 64'd0);
        chk("t6_rst_state", 64'(o_dbg_state), 64'd0);
        chk("t6_rst_err", 64'(o_error), 64'd0);
        chk("t6_rst_done", 64'(o_graph_done), 64'd0);
        chk("t6_rst_stall", o_stall, 64'd0);
        i_wr_rdy = 1'b1;
        node(12'h2A1, 1'b0, 1'b0);
        node(12'h0C8, 1'b0, 1'b0);
        chk("t6_cnt_cleared", 64'(o_wr_addr), 64'h0C0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
